// File: rtl/alu_issue_ctrl.sv
// Issue controller between a register-read stage and an R-type ALU datapath:
// accepts one instruction at a time, sequences EXEC/MULTU timing, returns the result.
module alu_issue_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] SIG_NOP = 6'b111111;

  localparam logic [5:0] EXEC_LAST = 6'(ALU_LAT - 1);
  localparam logic [5:0] MUL_LAST  = 6'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic [5:0]  op_funct;
  logic [4:0]  op_rd;
  logic [4:0]  op_shamt;
  logic [31:0] op_rs;
  logic [31:0] op_rt;

  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic        in_legal;
  logic        in_is_mul;
  logic        accept;
  logic        exec_last;
  logic        mul_last;

  assign in_opcode = instr[31:26];
  assign in_funct  = instr[5:0];
  assign in_is_mul = (in_funct == F_MULTU);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    in_legal = 1'b0;
    if (in_opcode == 6'd0) begin
      case (in_funct)
        F_AND, F_OR, F_ADD, F_SUB, F_SLT,
        F_SRL, F_MULTU, F_MFHI, F_MFLO: in_legal = 1'b1;
        default:                        in_legal = 1'b0;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign exec_last = (cnt == EXEC_LAST);
  assign mul_last  = (cnt == MUL_LAST);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = 6'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_legal)      state_next = DONE;
          else if (in_is_mul) state_next = MUL_WAIT;
          else                state_next = EXEC;
        end
      end
      EXEC: begin
        if (exec_last) state_next = DONE;
        else           cnt_next   = cnt + 6'd1;
      end
      MUL_WAIT: begin
        // HI/LO are written by the datapath itself, so nothing returns to write-back.
        if (mul_last) state_next = IDLE;
        else          cnt_next   = cnt + 6'd1;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the operand latches carry no reset; they are only observed after being loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_funct <= in_funct;
      op_rd    <= instr[15:11];
      op_shamt <= instr[10:6];
      op_rs    <= rs_data;
      op_rt    <= rt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= 32'd0;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else if (accept && !in_legal) begin
      out_data    <= 32'd0;
      out_rd      <= instr[15:11];
      out_illegal <= 1'b1;
    end else if (state == EXEC && exec_last) begin
      out_data    <= (op_rd == 5'd0) ? 32'd0 : alu_result;
      out_rd      <= op_rd;
      out_illegal <= 1'b0;
    end
  end

  always_comb begin
    alu_signal = SIG_NOP;
    alu_dataA  = 32'd0;
    alu_dataB  = 32'd0;
    if (state == EXEC || state == MUL_WAIT) begin
      alu_signal = op_funct;
      case (op_funct)
        F_SRL: begin
          alu_dataA = op_rt;
          alu_dataB = {27'd0, op_shamt};
        end
        F_MFHI, F_MFLO: begin
          alu_dataA = 32'd0;
          alu_dataB = 32'd0;
        end
        default: begin
          alu_dataA = op_rs;
          alu_dataB = op_rt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU/HI-LO stub plus a scoreboard of
// architectural results pushed at issue and popped at write-back.
module tb_alu_issue_ctrl;
  localparam int MUL_CYCLES = 32;
  localparam int ALU_LAT    = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        in_ready;
  logic [31:0] alu_dataA, alu_dataB, alu_result, out_data;
  logic [5:0]  alu_signal;
  logic        out_valid, out_illegal;
  logic [4:0]  out_rd;

  alu_issue_ctrl #(.MUL_CYCLES(MUL_CYCLES), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Datapath stub: combinational ALU, HI/LO written while MULTU is presented.
  logic [31:0] hi = 32'd0, lo = 32'd0;
  always_comb begin
    alu_result = 32'd0;
    case (alu_signal)
      6'd36:   alu_result = alu_dataA & alu_dataB;
      6'd37:   alu_result = alu_dataA | alu_dataB;
      6'd32:   alu_result = alu_dataA + alu_dataB;
      6'd34:   alu_result = alu_dataA - alu_dataB;
      6'd42:   alu_result = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      6'd2:    alu_result = alu_dataA >> alu_dataB[4:0];
      6'd16:   alu_result = hi;
      6'd18:   alu_result = lo;
      default: alu_result = 32'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (alu_signal == 6'd25) {hi, lo} <= 64'(alu_dataA) * 64'(alu_dataB);
  end

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        illegal;
    logic        chk_rd;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [5:0] funct,
                                       input logic [4:0] rd, input logic [4:0] shamt);
    return {op, 5'd1, 5'd2, rd, shamt, funct};
  endfunction

  // Architectural expectation for one instruction, computed from its fields.
  task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    int          k = 0;
    logic [5:0]  f = w[5:0];
    logic [4:0]  rd = w[15:11];
    logic        legal;
    logic [31:0] r;
    exp_t        e;
    logic [63:0] p;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_wait: in_ready=%b required 1", in_ready);
    end
    legal = (w[31:26] == 6'd0) && (f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42,
                                            6'd2, 6'd25, 6'd16, 6'd18});
    case (f)
      6'd36:   r = a & b;
      6'd37:   r = a | b;
      6'd32:   r = a + b;
      6'd34:   r = a - b;
      6'd42:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:    r = b >> w[10:6];
      6'd16:   r = m_hi;
      6'd18:   r = m_lo;
      default: r = 32'd0;
    endcase
    if (!legal) begin
      e = '{data: 32'd0, rd: rd, illegal: 1'b1, chk_rd: 1'b0};
      sb.push_back(e);
    end else if (f == 6'd25) begin
      p = 64'(a) * 64'(b);
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else begin
      e = '{data: (rd == 5'd0) ? 32'd0 : r, rd: rd, illegal: 1'b0, chk_rd: 1'b1};
      sb.push_back(e);
    end
    instr = w; rs_data = a; rt_data = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    int   k = 0;
    exp_t e;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!out_valid || sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_valid: out_valid=%b queued=%0d required 1 and >0", name, out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (out_data !== e.data) begin
        n_bad++; $display("FAIL %s_data: got %h required %h", name, out_data, e.data);
      end
      n_cmp++;
      if (out_illegal !== e.illegal) begin
        n_bad++; $display("FAIL %s_illegal: got %b required %b", name, out_illegal, e.illegal);
      end
      if (e.chk_rd) begin
        n_cmp++;
        if (out_rd !== e.rd) begin
          n_bad++; $display("FAIL %s_rd: got %0d required %0d", name, out_rd, e.rd);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_illegal !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_out: valid=%b ill=%b data=%h rd=%0d required all 0",
               out_valid, out_illegal, out_data, out_rd);
    end
    n_cmp++;
    if (alu_signal !== 6'h3F || alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_alu: sig=%h A=%h B=%h required 3f/0/0", alu_signal, alu_dataA, alu_dataB);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add;
    issue(mk_r(6'd0, 6'd32, 5'd3, 5'd0), 32'd5, 32'd7);
    n_cmp++;
    if (alu_signal !== 6'd32 || alu_dataA !== 32'd5 || alu_dataB !== 32'd7 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL add_exec: sig=%0d A=%0d B=%0d rdy=%b required 32/5/7/0",
               alu_signal, alu_dataA, alu_dataB, in_ready);
    end
    collect("add");
  endtask

  task automatic test_srl;
    issue(mk_r(6'd0, 6'd2, 5'd9, 5'd4), 32'h0000_1234, 32'h8000_0000);
    n_cmp++;
    if (alu_dataA !== 32'h8000_0000 || alu_dataB !== 32'd4 || alu_signal !== 6'd2) begin
      n_bad++;
      $display("FAIL srl_route: A=%h B=%h sig=%0d required 80000000/4/2", alu_dataA, alu_dataB, alu_signal);
    end
    collect("srl");
  endtask

  task automatic test_multu;
    int   nsig = 0;
    logic bad_rdy = 1'b0, bad_ov = 1'b0, bad_op = 1'b0;
    issue(mk_r(6'd0, 6'd25, 5'd0, 5'd0), 32'd3, 32'd4);
    for (int i = 0; i < MUL_CYCLES + 8; i++) begin
      if (alu_signal == 6'd25) begin
        nsig++;
        if (in_ready !== 1'b0) bad_rdy = 1'b1;
        if (alu_dataA !== 32'd3 || alu_dataB !== 32'd4) bad_op = 1'b1;
      end
      if (out_valid !== 1'b0) bad_ov = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (nsig != MUL_CYCLES) begin
      n_bad++; $display("FAIL multu_cycles: got %0d required %0d", nsig, MUL_CYCLES);
    end
    n_cmp++;
    if (bad_rdy || bad_ov || bad_op) begin
      n_bad++; $display("FAIL multu_hold: rdy_err=%b valid_err=%b operand_err=%b required 0/0/0",
                        bad_rdy, bad_ov, bad_op);
    end
    issue(mk_r(6'd0, 6'd18, 5'd4, 5'd0), 32'hDEAD_BEEF, 32'hCAFE_F00D);
    n_cmp++;
    if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0 || alu_signal !== 6'd18) begin
      n_bad++; $display("FAIL mflo_route: A=%h B=%h sig=%0d required 0/0/18", alu_dataA, alu_dataB, alu_signal);
    end
    collect("mflo");
    issue(mk_r(6'd0, 6'd25, 5'd0, 5'd0), 32'hFFFF_FFFF, 32'd2);
    issue(mk_r(6'd0, 6'd16, 5'd5, 5'd0), 32'd0, 32'd0);
    collect("mfhi");
    issue(mk_r(6'd0, 6'd18, 5'd6, 5'd0), 32'd0, 32'd0);
    collect("mflo_big");
  endtask

  task automatic test_illegal;
    logic [31:0] words[2];
    words[0] = mk_r(6'h23, 6'd32, 5'd8, 5'd0);
    words[1] = mk_r(6'd0, 6'h3F, 5'd8, 5'd0);
    for (int i = 0; i < 2; i++) begin
      issue(words[i], 32'd11, 32'd22);
      n_cmp++;
      if (alu_signal !== 6'h3F || alu_dataA !== 32'd0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal_%0d_issue: sig=%h A=%h valid=%b required 3f/0/1", i, alu_signal, alu_dataA, out_valid);
      end
      collect("illegal");
    end
  endtask

  task automatic test_hold;
    int   k = 0;
    logic bad = 1'b0;
    exp_t e;
    issue(mk_r(6'd0, 6'd34, 5'd7, 5'd0), 32'd20, 32'd8);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    instr = mk_r(6'd0, 6'd32, 5'd9, 5'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'd12 || out_rd !== 5'd7 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL hold_stable: valid=%b data=%0d rd=%0d rdy=%b required 1/12/7/0",
                        out_valid, out_data, out_rd, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: rdy=%b valid=%b required 1/0", in_ready, out_valid);
    end
    e = sb.pop_front();
    n_cmp++;
    if (e.data !== 32'd12) begin
      n_bad++; $display("FAIL hold_model: got %0d required 12", e.data);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_no_accept: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_rd_zero;
    issue(mk_r(6'd0, 6'd32, 5'd0, 5'd0), 32'd1, 32'd2);
    collect("rd_zero");
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops[6];
    ops[0] = 6'd36; ops[1] = 6'd37; ops[2] = 6'd32;
    ops[3] = 6'd34; ops[4] = 6'd42; ops[5] = 6'd2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        issue(mk_r(6'd0, ops[i], 5'(i + 10), 5'($urandom_range(0, 31))), $urandom, $urandom);
        collect("b2b");
      end
    end
  endtask

  task automatic test_reset_mid;
    logic bad = 1'b0;
    int   k = 0;
    issue(mk_r(6'd0, 6'd25, 5'd0, 5'd0), 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (alu_signal !== 6'h3F || alu_dataA !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mul: sig=%h A=%h valid=%b rdy=%b required 3f/0/0/1",
                        alu_signal, alu_dataA, out_valid, in_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < MUL_CYCLES + 8; i++) begin
      if (out_valid !== 1'b0 || alu_signal !== 6'h3F) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL rst_mul_after: op resurfaced, valid=%b sig=%h required 0/3f", out_valid, alu_signal);
    end
    issue(mk_r(6'd0, 6'd32, 5'd12, 5'd0), 32'd40, 32'd2);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_done: valid=%b data=%h rd=%0d rdy=%b required 0/0/0/1",
                        out_valid, out_data, out_rd, in_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL rst_done_after: out_valid reappeared");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_srl();
    test_multu();
    test_illegal();
    test_hold();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 32, meaning the cycles the Signal/operand bus is held for a MULTU (range 1..63).
REQ-002 The block SHALL have parameter ALU_LAT, default 1, meaning the cycles from issue to sampling alu_result for non-multiply ops (range 1..7).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 The block SHALL have port instr  input  32  R-type word: opcode[31:26], rd[15:11], shamt[10:6], funct[5:0].
REQ-008 The block SHALL have ports rs_data and rt_data  input  32 each  register operands.
REQ-009 The block SHALL have ports alu_dataA, alu_dataB  output  32 each, and alu_signal  output  6  drive to the ALU datapath.
REQ-010 The block SHALL have port alu_result  input  32  ALU datapath Output.
REQ-011 The block SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  32, out_rd  output  5, out_illegal  output  1  write-back handshake.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, MUL_WAIT, DONE; in_ready SHALL be 1 only in IDLE (single outstanding op, no bypass).
REQ-013 Handshake: instruction accepted on a cycle with in_valid=1 and in_ready=1; instr, rs_data, rt_data latched that edge.
REQ-014 Legal = opcode 0 and funct in {36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 2 SRL, 25 MULTU, 16 MFHI, 18 MFLO}.
REQ-015 Operand routing: SRL -> alu_dataA=rt, alu_dataB={27'b0,shamt}; MFHI/MFLO -> both 0; others -> alu_dataA=rs, alu_dataB=rt.
REQ-016 alu_signal SHALL equal latched funct in EXEC and MUL_WAIT and SHALL be 6'b111111 (no-op) in IDLE and DONE; operand outputs SHALL be 0 outside EXEC/MUL_WAIT.
REQ-017 Legal non-MULTU: IDLE -> EXEC for exactly ALU_LAT cycles; on last EXEC cycle alu_result captured into out_data; -> DONE.
REQ-018 MULTU: IDLE -> MUL_WAIT; 6-bit counter counts 0..MUL_CYCLES-1 holding signal/operands stable; then -> IDLE directly, no out_valid (HI/LO written internally by datapath).
REQ-019 Illegal instruction: IDLE -> DONE next cycle with out_illegal=1, out_data=0, nothing issued to the ALU.
REQ-020 DONE: out_valid=1; out_data, out_rd, out_illegal held stable until out_ready=1; on out_valid&out_ready -> IDLE.
REQ-021 rd=0 SHALL force out_data=0 (register $zero) while out_rd=0 and out_valid still asserted.
REQ-022 in_valid ignored while not in IDLE; in_valid in same cycle as DONE completion SHALL NOT be accepted that cycle.
REQ-023 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, counter 0, out_valid=0, out_illegal=0, out_data=0, out_rd=0, operands 0, alu_signal=6'b111111, regardless of state.
REQ-025 Reset mid-MUL_WAIT or mid-DONE SHALL drop the operation with no later out_valid; in_ready=1 the first cycle after reset deasserts.

Verification
REQ-026 ADD rs=5, rt=7, rd=3, ALU_LAT=1 -> alu_signal=32 one cycle, out_valid with out_data=12, out_rd=3.
REQ-027 SRL rt=0x80000000, shamt=4 -> alu_dataA=0x80000000, alu_dataB=4, out_data=0x08000000.
REQ-028 MULTU rs=3, rt=4 -> alu_signal=25 for exactly 32 cycles, in_ready=0 throughout, no out_valid; then MFLO -> out_data=12.
REQ-029 opcode 0x23 or funct 0x3F -> out_valid, out_illegal=1, out_data=0, alu_signal stays 6'b111111.
REQ-030 SUB result held with out_ready=0 for 5 cycles -> out_data unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-031 reset asserted on cycle 10 of MULTU -> next cycle IDLE, alu_signal=6'b111111, no out_valid ever for that op.
